sha_state_bank: RTL
===================

# sha_state_bank

Multi-channel SHA-256 hash-state store. It holds NUM_CH independent 8×32-bit chaining states and accumulates compression-round outputs into them (H[i] += word[i] mod 2^32). On a channel's last block it snapshots the final digest and streams it out word by word through a valid/ready handshake. It sits between the compression core and the digest output interface, so several messages can be hashed interleaved.

## Interface
- NUM_CH, 4: number of independent hash channels (≥1).
- CH_W, 2: channel index width, ≥ clog2(NUM_CH), ≥1.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_valid  in  1  load IV into channel init_ch this cycle; always accepted.
- init_ch  in  CH_W  channel to initialise.
- mode_224  in  1  with init_valid: select SHA-224 IV and 7-word digest (macro only).
- upd_valid  in  1  compression output offered.
- upd_ready  out  1  block may accept an update.
- upd_ch  in  CH_W  target channel.
- upd_last  in  1  this update completes the message; stream digest.
- upd_data  in  256  word i = bits[32i+31:32i], i=0 is H0.
- dig_valid  out  1  digest word valid.
- dig_ready  in  1  consumer accepts digest word.
- dig_data  out  32  digest word, H0 first.
- dig_ch  out  CH_W  channel of digest being streamed.
- dig_last  out  1  final digest word.
- rd_ch  in  CH_W  combinational readback select.
- rd_state  out  256  current chaining state of rd_ch, same packing as upd_data.
- rd_blocks  out  16  blocks accumulated into rd_ch since init.

## Operation
- Reset: every channel loads the SHA-256 IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19). Block counts and mode bits clear. FSM goes to IDLE. dig_valid=0, dig_data=0, dig_ch=0, dig_last=0. upd_ready=1 from the first cycle after reset.
- Init: the channel's state takes the IV and its block count clears to 0. Init is independent of the FSM and can target any channel, including one whose digest is streaming.
- Update: accepted when upd_valid && upd_ready.
  - Each word: state[ch][i] <= state[ch][i] + upd_data word i, mod 2^32.
  - Carries never propagate between words.
  - The block count increments and wraps from ffff to 0000.
- upd_ready = (FSM==IDLE) && !(init_valid && init_ch==upd_ch). On the same channel, init has priority and the update stalls.
- Accepted update with upd_last=1: the post-add sums are snapshotted into the output shift register, dig_ch<=upd_ch, and the FSM goes IDLE→STREAM. The channel's state also keeps the sums.
- STREAM:
  - dig_valid=1 and dig_data = current snapshot word.
  - On each dig_valid && dig_ready the index advances.
  - dig_last=1 on word 7, or word 6 in 224 mode.
  - Acceptance of the last word returns the FSM to IDLE and sets dig_valid=0.
- Later init or updates do not affect the snapshot. An init to dig_ch mid-stream does not alter the streamed digest.
- dig_data/dig_ch hold stable while dig_valid && !dig_ready.
- rd_state/rd_blocks are combinational from registered state; a write is visible the cycle after it.

## Timing
- Update latency: 1 cycle (rd_state reflects the sum on cycle N+1).
- Digest: dig_valid rises the cycle after the last update is accepted. With dig_ready held high, 8 words (or 7) take 8 (or 7) consecutive cycles, and upd_ready returns the cycle after the last word.
- Reset mid-stream: dig_valid drops the next cycle, all channels revert to the SHA-256 IV, and the stream is lost.
- Maximum update throughput: 1 per cycle in IDLE.

## Configuration
- SHA_STATE_SHA224_EN defined:
  - mode_224 is honoured on init. The SHA-224 IV is c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4.
  - The per-channel mode bit sets a 7-word digest (H0..H6).
- Undefined: mode_224 is ignored, no mode storage is built, and the digest is always 8 words with the SHA-256 IV.

## Test plan
- Reset, rd_ch=0 → rd_state H0=6a09e667, H7=5be0cd19, rd_blocks=0, dig_valid=0, upd_ready=1.
- Update ch2 with every word = 00000001, upd_last=0 → ch2 H0=6a09e668, H7=5be0cd1a, rd_blocks=1. Ch0, ch1 and ch3 are unchanged.
- Update ch0 with word1 = 44985183 → H1 wraps to 00000008, H0/H2 unchanged (no inter-word carry).
- Same-cycle init_valid/init_ch=1 and upd_valid/upd_ch=1 → upd_ready=0, ch1 = IV, rd_blocks=0. The update is accepted the next cycle.
- Last update on ch3 with dig_ready toggling 1,0,1… → 8 words H0..H7 in order, each held while stalled, dig_last only on word 8. An init of ch3 during the stream leaves the streamed words unchanged.
- With SHA_STATE_SHA224_EN: init ch1 with mode_224=1, then last update with zero data → H0=c1059ed8, 7 words streamed, dig_last on word 7.

Source files
------------

// File: rtl/sha_state_bank_if.sv
// Purpose: bundle of the init, update, digest and readback signals of sha_state_bank.
// Modports:
//   master - the compression core / controller side: drives init, update,
//            dig_ready and readback select; observes ready, digest and readback.
//   slave  - the hash-state store itself.
// Signals (CH_W = channel index width):
//   init_valid, init_ch, mode_224    : load an IV into a channel
//   upd_valid/upd_ready, upd_ch,
//   upd_last, upd_data[255:0]        : accumulate a compression output
//   dig_valid/dig_ready, dig_data,
//   dig_ch, dig_last                 : streamed digest, H0 first
//   rd_ch, rd_state, rd_blocks       : combinational readback of a channel
interface sha_state_bank_if #(
    parameter int unsigned CH_W = 2
) ();
    logic              init_valid;
    logic [CH_W-1:0]   init_ch;
    logic              mode_224;

    logic              upd_valid;
    logic              upd_ready;
    logic [CH_W-1:0]   upd_ch;
    logic              upd_last;
    logic [255:0]      upd_data;

    logic              dig_valid;
    logic              dig_ready;
    logic [31:0]       dig_data;
    logic [CH_W-1:0]   dig_ch;
    logic              dig_last;

    logic [CH_W-1:0]   rd_ch;
    logic [255:0]      rd_state;
    logic [15:0]       rd_blocks;

    modport master (
        output init_valid, init_ch, mode_224,
        output upd_valid, upd_ch, upd_last, upd_data,
        input  upd_ready,
        input  dig_valid, dig_data, dig_ch, dig_last,
        output dig_ready,
        output rd_ch,
        input  rd_state, rd_blocks
    );

    modport slave (
        input  init_valid, init_ch, mode_224,
        input  upd_valid, upd_ch, upd_last, upd_data,
        output upd_ready,
        output dig_valid, dig_data, dig_ch, dig_last,
        input  dig_ready,
        input  rd_ch,
        output rd_state, rd_blocks
    );
endinterface

// File: rtl/sha_state_bank.sv
// Purpose: multi-channel SHA-256 chaining-state store. Each channel holds
// eight 32-bit words that accumulate compression outputs (H[i] += word[i],
// mod 2^32, no carries between words). A last update snapshots the final
// digest and streams it out one word per handshake, H0 first.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - sha_state_bank_if.slave (init / update / digest / readback)
// Optional feature macro: SHA_STATE_SHA224_EN
//   defined   - mode_224 on init selects the SHA-224 IV and a 7-word digest
//   undefined - mode_224 ignored, always SHA-256 IV and 8-word digest
module sha_state_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    sha_state_bank_if.slave  bus
);
    localparam int unsigned WORDS  = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;

    // Element 0 is H0 (concatenation lists H7 first).
    localparam logic [WORDS-1:0][WORD_W-1:0] IV_256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
`ifdef SHA_STATE_SHA224_EN
    localparam logic [WORDS-1:0][WORD_W-1:0] IV_224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };
`endif
    localparam logic [IDX_W-1:0] LAST_256 = IDX_W'(7);
    localparam logic [IDX_W-1:0] LAST_224 = IDX_W'(6);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } fsm_t;

    logic [WORDS-1:0][WORD_W-1:0] r_state  [NUM_CH];
    logic [CNT_W-1:0]             r_blocks [NUM_CH];
`ifdef SHA_STATE_SHA224_EN
    logic                         r_mode   [NUM_CH];
`endif

    fsm_t                         r_fsm;
    logic [WORDS-1:0][WORD_W-1:0] r_snap;
    logic [IDX_W-1:0]             r_idx;
    logic [IDX_W-1:0]             r_last_idx;
    logic                         r_dig_valid;
    logic                         r_dig_last;
    logic [WORD_W-1:0]            r_dig_data;
    logic [CH_W-1:0]              r_dig_ch;

    logic [WORDS-1:0][WORD_W-1:0] w_upd_data;
    logic [WORDS-1:0][WORD_W-1:0] w_cur;
    logic [WORDS-1:0][WORD_W-1:0] w_sum;
    logic [WORDS-1:0][WORD_W-1:0] w_rd_state;
    logic [CNT_W-1:0]             w_rd_blocks;
    logic [IDX_W-1:0]             w_cur_last;
    logic                         w_upd_ready;
    logic                         w_upd_fire;
    logic [IDX_W-1:0]             w_idx_nxt;

    // Same-channel init wins; the update waits a cycle.
    assign w_upd_ready = (r_fsm == ST_IDLE) &&
                         !(bus.init_valid && (bus.init_ch == bus.upd_ch));
    assign w_upd_fire  = bus.upd_valid && w_upd_ready;
    assign w_upd_data  = bus.upd_data;
    assign w_idx_nxt   = r_idx + IDX_W'(1);

    // Channel selects for the update target and the readback port.
    always_comb begin
        w_cur       = '0;
        w_cur_last  = LAST_256;
        w_rd_state  = '0;
        w_rd_blocks = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.upd_ch == CH_W'(c)) begin
                w_cur = r_state[c];
`ifdef SHA_STATE_SHA224_EN
                w_cur_last = r_mode[c] ? LAST_224 : LAST_256;
`endif
            end
            if (bus.rd_ch == CH_W'(c)) begin
                w_rd_state  = r_state[c];
                w_rd_blocks = r_blocks[c];
            end
        end
    end

    // Independent 32-bit adders: no carry between words.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_sum[i] = w_cur[i] + w_upd_data[i];
        end
    end

    // Per-channel state, block count and mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]  <= IV_256;
                r_blocks[c] <= '0;
`ifdef SHA_STATE_SHA224_EN
                r_mode[c]   <= 1'b0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.init_valid && (bus.init_ch == CH_W'(c))) begin
`ifdef SHA_STATE_SHA224_EN
                    r_state[c] <= bus.mode_224 ? IV_224 : IV_256;
                    r_mode[c]  <= bus.mode_224;
`else
                    r_state[c] <= IV_256;
`endif
                    r_blocks[c] <= '0;
                end else if (w_upd_fire && (bus.upd_ch == CH_W'(c))) begin
                    r_state[c]  <= w_sum;
                    r_blocks[c] <= r_blocks[c] + CNT_W'(1);
                end
            end
        end
    end

    // Digest streaming FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= ST_IDLE;
            r_snap      <= '0;
            r_idx       <= '0;
            r_last_idx  <= LAST_256;
            r_dig_valid <= 1'b0;
            r_dig_last  <= 1'b0;
            r_dig_data  <= '0;
            r_dig_ch    <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_upd_fire && bus.upd_last) begin
                        r_snap      <= w_sum;
                        r_idx       <= '0;
                        r_last_idx  <= w_cur_last;
                        r_dig_data  <= w_sum[0];
                        r_dig_ch    <= bus.upd_ch;
                        r_dig_valid <= 1'b1;
                        r_dig_last  <= 1'b0;
                        r_fsm       <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (bus.dig_ready) begin
                        if (r_dig_last) begin
                            r_dig_valid <= 1'b0;
                            r_dig_last  <= 1'b0;
                            r_fsm       <= ST_IDLE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_dig_data <= r_snap[w_idx_nxt];
                            r_dig_last <= (w_idx_nxt == r_last_idx);
                        end
                    end
                end
                default: begin
                    r_fsm       <= ST_IDLE;
                    r_dig_valid <= 1'b0;
                    r_dig_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.upd_ready = w_upd_ready;
    assign bus.dig_valid = r_dig_valid;
    assign bus.dig_data  = r_dig_data;
    assign bus.dig_ch    = r_dig_ch;
    assign bus.dig_last  = r_dig_last;
    assign bus.rd_state  = w_rd_state;
    assign bus.rd_blocks = w_rd_blocks;

endmodule
